serdes_tx_cc: RTL and testbench
===============================

# serdes_tx_cc

Parametrised second-generation SERDES transmit front end, sitting between DSP-side producers and the external SERDES transmit pins in the DSP clock domain. It buffers guarded write requests in a configurable FIFO and drives registered data and K-flag outputs. When the FIFO is empty or the link is disabled, it drives an idle comma. Unlike the first-generation block, it has a byte-lane count parameter, periodic clock-correction (CC) insertion, an overflow flag and an idle-cycle counter.

## Interface
- NBYTES, 2: byte lanes per word; data width is 8*NBYTES, K width is NBYTES
- FIFO_DEPTH, 4: buffer entries; power of two, at least 2
- CNT_W, 2: log2(FIFO_DEPTH)
- IDLE_WORD, {NBYTES{8'h3C}}: idle pattern (K28.1 per lane), sent with all K flags set
- CC_WORD, {NBYTES{8'hF7}}: clock-correction pattern (K23.7 per lane), sent with all K flags set
- CC_PERIOD, 5000: output cycles from the end of one CC burst to the start of the next; at least CC_LEN+1
- CC_LEN, 2: words per CC burst; at least 1
- dsp_clk  in  1  sole clock
- dsp_rst_n  in  1  asynchronous, active-low reset
- tx_dat_i  in  8*NBYTES  write data
- tx_k_i  in  NBYTES  per-lane K flags; bit i qualifies byte i
- tx_en  in  1  enqueue strobe; assert only while tx_rdy is high
- tx_rdy  out  1  FIFO not full
- link_en  in  1  transmit enable; when low, output idle and hold the FIFO
- stat_clr  in  1  synchronous clear of overflow and idle_cnt
- ser_tx_clk  out  1  equals dsp_clk
- ser_t  out  8*NBYTES  registered SERDES data
- ser_tk  out  NBYTES  registered SERDES K flags
- fifo_level  out  CNT_W+1  current occupancy, 0..FIFO_DEPTH
- cc_active  out  1  registered; high on cycles where ser_t carries CC_WORD
- overflow  out  1  sticky; set by tx_en while tx_rdy is low
- idle_cnt  out  16  saturating count of idle words emitted while link_en is high

## Operation
- States: OFF, DATA, CC.
  - Reset enters OFF.
  - OFF goes to DATA on the first cycle with link_en high.
  - Any state goes to OFF whenever link_en is low. This takes priority and aborts a CC burst immediately.
- Each cycle, the output word is chosen by state:
  - DATA with FIFO non-empty: output the FIFO head and dequeue it in the same cycle.
  - DATA with FIFO empty: output IDLE_WORD/all-ones K, no dequeue, increment idle_cnt (saturating at 16'hFFFF).
  - CC: output CC_WORD/all-ones K, no dequeue, even if the FIFO is non-empty.
  - OFF: output IDLE_WORD/all-ones K, no dequeue, idle_cnt unchanged.
- CC timer:
  - Counts output cycles spent in DATA.
  - When it reaches CC_PERIOD-1, the next state is CC, regardless of FIFO contents.
  - CC lasts exactly CC_LEN cycles, then returns to DATA with the timer at 0.
  - OFF holds the timer at 0.
- Enqueue:
  - tx_en with tx_rdy high writes {tx_k_i, tx_dat_i}.
  - tx_en with tx_rdy low is dropped and sets overflow.
  - A simultaneous enqueue and dequeue when the FIFO is full is not accepted, because tx_rdy is already low.
  - A simultaneous enqueue and dequeue at any other level leaves fifo_level unchanged.
- stat_clr clears overflow and idle_cnt. If a set or increment event occurs in the same cycle, stat_clr wins.
- The FIFO has no clear input. Contents survive OFF and are lost only on reset.

## Timing
- Reset values:
  - ser_t = IDLE_WORD, ser_tk = all ones.
  - cc_active = 0, overflow = 0, idle_cnt = 0.
  - fifo_level = 0, tx_rdy = 1, state OFF, CC timer = 0.
- Output latency:
  - A word enqueued at clock edge N into an empty FIFO, in DATA, appears on ser_t after edge N+2: one cycle of FIFO write plus one output register.
  - A word already at the FIFO head appears on ser_t one edge after it is selected.
- Flags: tx_rdy and fifo_level are combinational from FIFO state and update one edge after each enqueue or dequeue.
- Throughput: one word per cycle in DATA; zero in CC and OFF.
- link_en transitions:
  - Low sampled at edge N: ser_t is idle from edge N+1.
  - High sampled at edge N: the first FIFO word can appear at edge N+2.
- Asynchronous reset mid-burst or mid-transfer: all outputs take their reset values immediately, and buffered words are discarded.

## Structure
- Package serdes_tx_pkg holds:
  - K28_1 = 8'h3C and K23_7 = 8'hF7;
  - the state enum {OFF, DATA, CC};
  - the idle_cnt width constant (16).
- Sub-module serdes_tx_fifo:
  - synchronous FIFO, width 9*NBYTES, depth FIFO_DEPTH, asynchronous active-low reset;
  - ports: enq, deq, full_n, empty_n, level, head data;
  - instantiated once.
- The top level contains the FSM, CC timer, output registers and statistics.

## Test plan
- Reset, then link_en=1 with no writes: ser_t = 16'h3C3C, ser_tk = 2'b11 continuously; idle_cnt increments by one per cycle; after CC_PERIOD=8 test cycles, exactly CC_LEN=2 cycles of 16'hF7F7 with cc_active=1.
- Write 16'h1234 with K=00 at edge N, FIFO empty: ser_t = 16'h1234, ser_tk = 00 after edge N+2, then idle.
- Burst of 6 writes, depth 4, no dequeue (link_en=0): tx_rdy falls after the 4th write; writes 5 and 6 dropped; overflow=1; after link_en=1 the four stored words emerge in order, then idle.
- Continuous streaming with CC_PERIOD=8: a CC burst of 2 words interrupts the data; no word lost, duplicated or reordered; fifo_level rises by 2 across the burst.
- link_en dropped during the first CC word: next output is idle, and cc_active=0 on the following cycle; on re-enable the first CC burst comes CC_PERIOD cycles later.
- dsp_rst_n asserted mid-stream with level 3: outputs idle immediately, fifo_level=0, overflow=0; stat_clr coincident with an idle increment leaves idle_cnt=0.

Source files
------------

// File: rtl/serdes_tx_pkg.sv
// Shared constants, state encoding and helpers for the second-generation SERDES transmit front end.
package serdes_tx_pkg;

    localparam logic [7:0] K28_1      = 8'h3C;
    localparam logic [7:0] K23_7      = 8'hF7;
    localparam int         IDLE_CNT_W = 16;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DATA = 2'd1,
        CC   = 2'd2
    } tx_state_e;

    function automatic logic [IDLE_CNT_W-1:0] sat_inc(input logic [IDLE_CNT_W-1:0] v);
        if (v == {IDLE_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + IDLE_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/serdes_tx_cc_if.sv
// Producer-side request/flag bundle and SERDES-side output bundle of serdes_tx_cc.
interface serdes_tx_cc_if
    import serdes_tx_pkg::*;
#(
    parameter int unsigned NBYTES = 2,
    parameter int unsigned CNT_W  = 2
);
    logic [8*NBYTES-1:0]   tx_dat_i;
    logic [NBYTES-1:0]     tx_k_i;
    logic                  tx_en;
    logic                  tx_rdy;
    logic                  link_en;
    logic                  stat_clr;
    logic [8*NBYTES-1:0]   ser_t;
    logic [NBYTES-1:0]     ser_tk;
    logic [CNT_W:0]        fifo_level;
    logic                  cc_active;
    logic                  overflow;
    logic [IDLE_CNT_W-1:0] idle_cnt;

    modport master (
        output tx_dat_i, tx_k_i, tx_en, link_en, stat_clr,
        input  tx_rdy, ser_t, ser_tk, fifo_level, cc_active, overflow, idle_cnt
    );

    modport slave (
        input  tx_dat_i, tx_k_i, tx_en, link_en, stat_clr,
        output tx_rdy, ser_t, ser_tk, fifo_level, cc_active, overflow, idle_cnt
    );
endinterface

// File: rtl/serdes_tx_fifo.sv
// Synchronous FIFO buffering {K, data} entries ahead of the SERDES output mux.
module serdes_tx_fifo #(
    parameter int unsigned W     = 18,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enq_i,
    input  logic [W-1:0]   enq_data_i,
    input  logic           deq_i,
    output logic           full_n_o,
    output logic           empty_n_o,
    output logic [CNT_W:0] level_o,
    output logic [W-1:0]   head_o
);
    localparam int unsigned LW = CNT_W + 1;
    localparam logic [CNT_W:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] wr_q;
    logic [CNT_W-1:0] rd_q;
    logic [CNT_W:0]   cnt_q;
    logic             wr_s;
    logic             rd_s;

    assign full_n_o  = (cnt_q != FULL_LVL);
    assign empty_n_o = (cnt_q != '0);
    assign level_o   = cnt_q;
    assign head_o    = mem_q[rd_q];
    assign wr_s      = enq_i & full_n_o;
    assign rd_s      = deq_i & empty_n_o;

    // Storage array; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_q] <= enq_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_s) begin
                wr_q <= wr_q + CNT_W'(1);
            end
            if (rd_s) begin
                rd_q <= rd_q + CNT_W'(1);
            end
            case ({wr_s, rd_s})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/serdes_tx_cc.sv
// SERDES transmit front end: FIFO-buffered data, idle commas when starved or disabled,
// and periodic clock-correction bursts, all on registered outputs.
module serdes_tx_cc
    import serdes_tx_pkg::*;
#(
    parameter int unsigned         NBYTES     = 2,
    parameter int unsigned         FIFO_DEPTH = 4,
    parameter int unsigned         CNT_W      = 2,
    parameter logic [8*NBYTES-1:0] IDLE_WORD  = {NBYTES{K28_1}},
    parameter logic [8*NBYTES-1:0] CC_WORD    = {NBYTES{K23_7}},
    parameter int unsigned         CC_PERIOD  = 5000,
    parameter int unsigned         CC_LEN     = 2
) (
    input  logic          dsp_clk,
    input  logic          dsp_rst_n,
    output logic          ser_tx_clk,
    serdes_tx_cc_if.slave bus
);
    localparam int unsigned DW    = 8 * NBYTES;
    localparam int unsigned FW    = 9 * NBYTES;
    localparam int unsigned TMR_W = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
    localparam int unsigned CCN_W = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CC_PERIOD - 1);
    localparam logic [CCN_W-1:0] CCN_LAST = CCN_W'(CC_LEN - 1);

    logic                  full_n_s;
    logic                  empty_n_s;
    logic [CNT_W:0]        level_s;
    logic [FW-1:0]         head_s;
    logic                  deq_s;
    logic                  idle_ev_s;

    tx_state_e             state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [CCN_W-1:0]      ccn_q, ccn_d;
    logic [DW-1:0]         ser_t_q, ser_t_d;
    logic [NBYTES-1:0]     ser_tk_q, ser_tk_d;
    logic                  cc_q, cc_d;
    logic                  ovf_q, ovf_d;
    logic [IDLE_CNT_W-1:0] idle_q, idle_d;

    serdes_tx_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (dsp_clk),
        .rst_n      (dsp_rst_n),
        .enq_i      (bus.tx_en),
        .enq_data_i ({bus.tx_k_i, bus.tx_dat_i}),
        .deq_i      (deq_s),
        .full_n_o   (full_n_s),
        .empty_n_o  (empty_n_s),
        .level_o    (level_s),
        .head_o     (head_s)
    );

    assign ser_tx_clk     = dsp_clk;
    assign bus.tx_rdy     = full_n_s;
    assign bus.fifo_level = level_s;
    assign bus.ser_t      = ser_t_q;
    assign bus.ser_tk     = ser_tk_q;
    assign bus.cc_active  = cc_q;
    assign bus.overflow   = ovf_q;
    assign bus.idle_cnt   = idle_q;

    // Next state, CC timer and output word; a low link_en overrides every state, even mid-burst.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        ccn_d     = ccn_q;
        ser_t_d   = IDLE_WORD;
        ser_tk_d  = {NBYTES{1'b1}};
        cc_d      = 1'b0;
        deq_s     = 1'b0;
        idle_ev_s = 1'b0;
        if (!bus.link_en) begin
            state_d = OFF;
            tmr_d   = '0;
            ccn_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = DATA;
                    tmr_d   = '0;
                end
                DATA: begin
                    if (empty_n_s) begin
                        ser_t_d  = head_s[DW-1:0];
                        ser_tk_d = head_s[FW-1:DW];
                        deq_s    = 1'b1;
                    end else begin
                        idle_ev_s = 1'b1;
                    end
                    if (tmr_q == TMR_LAST) begin
                        state_d = CC;
                        tmr_d   = '0;
                        ccn_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                CC: begin
                    ser_t_d = CC_WORD;
                    cc_d    = 1'b1;
                    if (ccn_q == CCN_LAST) begin
                        state_d = DATA;
                        ccn_d   = '0;
                    end else begin
                        ccn_d = ccn_q + CCN_W'(1);
                    end
                end
                default: begin
                    state_d = OFF;
                    tmr_d   = '0;
                    ccn_d   = '0;
                end
            endcase
        end
    end

    // Statistics; stat_clr beats a coincident set or increment.
    always_comb begin
        if (bus.stat_clr) begin
            ovf_d  = 1'b0;
            idle_d = '0;
        end else begin
            ovf_d = ovf_q | (bus.tx_en & ~full_n_s);
            if (idle_ev_s) begin
                idle_d = sat_inc(idle_q);
            end else begin
                idle_d = idle_q;
            end
        end
    end

    // FSM state and all registered outputs.
    always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
        if (!dsp_rst_n) begin
            state_q  <= OFF;
            tmr_q    <= '0;
            ccn_q    <= '0;
            ser_t_q  <= IDLE_WORD;
            ser_tk_q <= {NBYTES{1'b1}};
            cc_q     <= 1'b0;
            ovf_q    <= 1'b0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            ccn_q    <= ccn_d;
            ser_t_q  <= ser_t_d;
            ser_tk_q <= ser_tk_d;
            cc_q     <= cc_d;
            ovf_q    <= ovf_d;
            idle_q   <= idle_d;
        end
    end

endmodule

// File: tb/tb_serdes_tx_cc.sv
// Self-checking bench for serdes_tx_cc: a per-cycle vector table plus directed
// sequences for streaming across CC bursts, link drop mid-burst and async reset.
module tb_serdes_tx_cc;
    localparam int CC_PERIOD = 8;
    localparam int CC_LEN    = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic ser_tx_clk;
    int   n_tests = 0;
    int   n_fail  = 0;

    serdes_tx_cc_if #(.NBYTES(2), .CNT_W(2)) bus ();

    serdes_tx_cc #(
        .NBYTES     (2),
        .FIFO_DEPTH (4),
        .CNT_W      (2),
        .IDLE_WORD  (16'h3C3C),
        .CC_WORD    (16'hF7F7),
        .CC_PERIOD  (CC_PERIOD),
        .CC_LEN     (CC_LEN)
    ) dut (
        .dsp_clk    (clk),
        .dsp_rst_n  (rst_n),
        .ser_tx_clk (ser_tx_clk),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] dat;
        logic [1:0]  k;
        logic        link;
        logic        clr;
        logic [15:0] e_t;
        logic [1:0]  e_tk;
        logic        e_cc;
        logic [2:0]  e_lvl;
        logic        e_rdy;
        logic        e_ovf;
        logic [15:0] e_idle;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic [15:0] dat, logic [1:0] k, logic link, logic clr,
                                logic [15:0] t, logic [1:0] tk, logic cc, logic [2:0] lvl,
                                logic rdy, logic ovf, logic [15:0] idle);
        vec_t v;
        v.en = en; v.dat = dat; v.k = k; v.link = link; v.clr = clr;
        v.e_t = t; v.e_tk = tk; v.e_cc = cc; v.e_lvl = lvl; v.e_rdy = rdy; v.e_ovf = ovf; v.e_idle = idle;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [15:0] dat, input logic [1:0] k,
                         input logic link, input logic clr);
        bus.tx_en    = en;
        bus.tx_dat_i = dat;
        bus.tx_k_i   = k;
        bus.link_en  = link;
        bus.stat_clr = clr;
    endtask

    initial begin
        logic [15:0] sent[$];
        int w;
        int run, gap, pre_lvl, prev_lvl, nbursts, nsent;
        logic prev_cc;

        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);

        // Rows: {en, dat, k, link, clr} -> {ser_t, ser_tk, cc, level, rdy, overflow, idle_cnt}
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 16'd0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 16'(i)));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'hF7F7, 2'b11, 1'b1, 3'd0, 1'b1, 1'b0, 16'd8));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'hF7F7, 2'b11, 1'b1, 3'd0, 1'b1, 1'b0, 16'd8));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 16'd9));
        vecs.push_back(mk(1'b1, 16'h1234, 2'b00, 1'b1, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd1, 1'b1, 1'b0, 16'd10));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h1234, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 16'd10));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 16'd11));
        vecs.push_back(mk(1'b1, 16'hA001, 2'b01, 1'b0, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd1, 1'b1, 1'b0, 16'd11));
        vecs.push_back(mk(1'b1, 16'hA002, 2'b10, 1'b0, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd2, 1'b1, 1'b0, 16'd11));
        vecs.push_back(mk(1'b1, 16'hA003, 2'b00, 1'b0, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd3, 1'b1, 1'b0, 16'd11));
        vecs.push_back(mk(1'b1, 16'hA004, 2'b11, 1'b0, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd4, 1'b0, 1'b0, 16'd11));
        vecs.push_back(mk(1'b1, 16'hA005, 2'b00, 1'b0, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd4, 1'b0, 1'b1, 16'd11));
        vecs.push_back(mk(1'b1, 16'hA006, 2'b00, 1'b0, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd4, 1'b0, 1'b1, 16'd11));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd4, 1'b0, 1'b1, 16'd11));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'hA001, 2'b01, 1'b0, 3'd3, 1'b1, 1'b1, 16'd11));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'hA002, 2'b10, 1'b0, 3'd2, 1'b1, 1'b1, 16'd11));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'hA003, 2'b00, 1'b0, 3'd1, 1'b1, 1'b1, 16'd11));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'hA004, 2'b11, 1'b0, 3'd0, 1'b1, 1'b1, 16'd11));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h3C3C, 2'b11, 1'b0, 3'd0, 1'b1, 1'b1, 16'd12));
        vecs.push_back(mk(1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h3C3C, 2'b11, 1'b0, 3'd0, 1'b1, 1'b0, 16'd0));

        // Reset state
        tick();
        tick();
        chk("rst ser_t", 32'(bus.ser_t), 32'h3C3C);
        chk("rst ser_tk", 32'(bus.ser_tk), 32'h3);
        chk("rst cc_active", 32'(bus.cc_active), 32'h0);
        chk("rst overflow", 32'(bus.overflow), 32'h0);
        chk("rst idle_cnt", 32'(bus.idle_cnt), 32'h0);
        chk("rst fifo_level", 32'(bus.fifo_level), 32'h0);
        chk("rst tx_rdy", 32'(bus.tx_rdy), 32'h1);
        chk("ser_tx_clk high", 32'(ser_tx_clk), 32'h1);
        @(negedge clk);
        #1;
        chk("ser_tx_clk low", 32'(ser_tx_clk), 32'h0);
        tick();
        rst_n = 1'b1;

        // Table: idle + first CC burst, single word latency, overflow burst, stat_clr vs idle increment
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].dat, vecs[i].k, vecs[i].link, vecs[i].clr);
            tick();
            chk($sformatf("v%0d ser_t", i), 32'(bus.ser_t), 32'(vecs[i].e_t));
            chk($sformatf("v%0d ser_tk", i), 32'(bus.ser_tk), 32'(vecs[i].e_tk));
            chk($sformatf("v%0d cc_active", i), 32'(bus.cc_active), 32'(vecs[i].e_cc));
            chk($sformatf("v%0d fifo_level", i), 32'(bus.fifo_level), 32'(vecs[i].e_lvl));
            chk($sformatf("v%0d tx_rdy", i), 32'(bus.tx_rdy), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("v%0d idle_cnt", i), 32'(bus.idle_cnt), 32'(vecs[i].e_idle));
        end

        // Streaming across CC bursts: order, no loss/duplication, burst length, gap, level rise
        run = 0; gap = -1; pre_lvl = 0; prev_lvl = 0; nbursts = 0; nsent = 0; prev_cc = 1'b0;
        for (int c = 0; c < 26; c++) begin
            if (c < 16 && bus.tx_rdy) begin
                drive(1'b1, 16'h5000 + 16'(nsent), 2'b00, 1'b1, 1'b0);
                sent.push_back(16'h5000 + 16'(nsent));
                nsent++;
            end else begin
                drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
            end
            tick();
            if (bus.cc_active) begin
                chk("stream cc word", 32'(bus.ser_t), 32'hF7F7);
                if (!prev_cc) begin
                    pre_lvl = prev_lvl;
                    if (gap >= 0) chk("cc gap", 32'(gap), 32'(CC_PERIOD));
                    nbursts++;
                end
                run++;
            end else begin
                if (prev_cc) begin
                    chk("cc burst len", 32'(run), 32'(CC_LEN));
                    if (nbursts == 1) chk("cc level rise", 32'(prev_lvl - pre_lvl), 32'd2);
                    run = 0;
                    gap = 0;
                end
                if (gap >= 0) gap++;
                if (bus.ser_tk == 2'b00) begin
                    if (sent.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL stream extra word: got %0h, expected none", bus.ser_t);
                    end else begin
                        chk("stream word", 32'(bus.ser_t), 32'(sent.pop_front()));
                    end
                end
            end
            prev_cc  = bus.cc_active;
            prev_lvl = int'(bus.fifo_level);
        end
        chk("stream undelivered", 32'(sent.size()), 32'd0);
        chk("stream bursts", 32'(nbursts), 32'd3);

        // Link dropped during the first CC word, then re-enabled
        w = 0;
        do begin tick(); w++; end while (!bus.cc_active && w < 20);
        chk("wait cc start", 32'(bus.cc_active), 32'h1);
        bus.link_en = 1'b0;
        tick();
        chk("drop ser_t", 32'(bus.ser_t), 32'h3C3C);
        chk("drop ser_tk", 32'(bus.ser_tk), 32'h3);
        chk("drop cc_active", 32'(bus.cc_active), 32'h0);
        bus.link_en = 1'b1;
        w = 0;
        do begin tick(); w++; end while (!bus.cc_active && w < 30);
        chk("reenable cc delay", 32'(w), 32'(CC_PERIOD + 2));

        // Async reset mid-stream with three words buffered and overflow set
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'hE000 + 16'(i), 2'b01, 1'b0, 1'b0);
            tick();
        end
        chk("pre-rst overflow", 32'(bus.overflow), 32'h1);
        drive(1'b0, 16'h0000, 2'b00, 1'b1, 1'b0);
        tick();
        tick();
        chk("pre-rst ser_t", 32'(bus.ser_t), 32'hE000);
        chk("pre-rst level", 32'(bus.fifo_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst ser_t", 32'(bus.ser_t), 32'h3C3C);
        chk("async rst ser_tk", 32'(bus.ser_tk), 32'h3);
        chk("async rst level", 32'(bus.fifo_level), 32'd0);
        chk("async rst overflow", 32'(bus.overflow), 32'h0);
        chk("async rst idle_cnt", 32'(bus.idle_cnt), 32'h0);
        chk("async rst tx_rdy", 32'(bus.tx_rdy), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("post-rst %0d ser_tk", i), 32'(bus.ser_tk), 32'h3);
            chk($sformatf("post-rst %0d level", i), 32'(bus.fifo_level), 32'd0);
        end
        chk("post-rst idle_cnt", 32'(bus.idle_cnt), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
